arm_run_controller: RTL and testbench

Synthesizable run controller for one or more ARM pipeline cores (`ARMModule` instances). It sequences each run:

- holds the cores in reset for a programmable stretch;
- applies a per-core forwarding mode that stays fixed for the whole run;
- counts execution cycles;
- ends the run when every core reports halt, on a cycle timeout, or on abort.

It replaces open-ended, time-bounded bring-up runs with a deterministic start/stop sequence usable on silicon and in regression.

---
 rtl/arm_run_pkg.sv | 20 ++
 rtl/arm_sat_counter.sv | 38 +++
 rtl/arm_run_controller.sv | 158 +++++++++++++++
 tb/tb_arm_run_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_run_pkg.sv
// Shared types for the ARM run controller: FSM state encoding and run exit cause.
package arm_run_pkg;

    // Run sequencing states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    // Why the FSM left its current state on a given edge.
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_HALT    = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_ABORT   = 2'd3
    } exit_cause_e;

endpackage

// File: rtl/arm_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module arm_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, else increment unless already at all-ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/arm_run_controller.sv
// Run controller for ARM cores: reset stretch, fixed per-run forwarding mode,
// cycle counting and run termination on all-halt, timeout or abort.
module arm_run_controller
    import arm_run_pkg::*;
#(
    parameter int NUM_CORES       = 1,
    parameter int RESET_CYCLES    = 2,
    parameter int CNT_W           = 16,
    parameter int DEFAULT_TIMEOUT = 500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     timeout_cycles,
    input  logic [NUM_CORES-1:0] fwd_mode_in,
    input  logic [NUM_CORES-1:0] core_halted,
    output logic [NUM_CORES-1:0] core_rst,
    output logic [NUM_CORES-1:0] forwarding_enabled,
    output logic                 running,
    output logic                 done,
    output logic                 timed_out,
    output logic [NUM_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]     cycle_count
);

    // Stretch counter only needs to hold 0..RESET_CYCLES-1.
    localparam int SW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

    run_state_e  state_q, state_d;
    exit_cause_e cause;

    logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 timed_out_q, timed_out_d;
    logic [NUM_CORES-1:0] fwd_q, fwd_d;
    logic [CNT_W-1:0]     timeout_q, timeout_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;

    logic [SW-1:0]    stretch_cnt;
    logic [CNT_W-1:0] run_cnt;

    logic start_accept;
    logic stretch_last;
    logic all_halted;
    logic timeout_hit;

    // A start only counts from IDLE or DONE, and abort always overrides it.
    assign start_accept = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign stretch_last = (stretch_cnt == SW'(RESET_CYCLES - 1));
    assign all_halted   = &(mask_q | core_halted);
    assign timeout_hit  = ((CNT_W+1)'(run_cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(timeout_q);

    arm_sat_counter #(.W(SW)) u_stretch_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != ST_RESET),
        .en_i  (state_q == ST_RESET),
        .cnt_o (stretch_cnt)
    );

    arm_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (abort || start_accept),
        .en_i  (state_q == ST_RUN),
        .cnt_o (run_cnt)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            core_rst_q  <= '1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_rst_q  <= core_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next state and the cause of leaving the current state; abort has top priority.
    always_comb begin
        state_d = state_q;
        cause   = CAUSE_NONE;
        if (abort) begin
            state_d = ST_IDLE;
            cause   = CAUSE_ABORT;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_RESET;
                ST_RESET: if (stretch_last) state_d = ST_RUN;
                ST_RUN: begin
                    if (all_halted) begin
                        state_d = ST_DONE;
                        cause   = CAUSE_HALT;
                    end else if (timeout_hit) begin
                        state_d = ST_DONE;
                        cause   = CAUSE_TIMEOUT;
                    end
                end
                ST_DONE:  if (start) state_d = ST_RESET;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs derived from the next state so they appear registered on the transition edge.
    always_comb begin
        core_rst_d  = ((state_d == ST_IDLE) || (state_d == ST_RESET)) ? '1 : '0;
        running_d   = (state_d == ST_RUN);
        done_d      = (state_d == ST_DONE);
        timed_out_d = (state_d == ST_DONE) &&
                      ((state_q == ST_DONE) ? timed_out_q : (cause == CAUSE_TIMEOUT));
    end

    // Per-run latches: forwarding mode, effective timeout and sticky halt mask.
    always_comb begin
        fwd_d     = fwd_q;
        timeout_d = timeout_q;
        mask_d    = mask_q;
        if (start_accept) begin
            fwd_d     = fwd_mode_in;
            timeout_d = (timeout_cycles == '0) ? CNT_W'(DEFAULT_TIMEOUT) : timeout_cycles;
            mask_d    = '0;
        end else if (!abort && (state_q == ST_RUN)) begin
            mask_d = mask_q | core_halted;
        end
    end

    // Latch registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_q     <= '0;
            timeout_q <= CNT_W'(DEFAULT_TIMEOUT);
            mask_q    <= '0;
        end else begin
            fwd_q     <= fwd_d;
            timeout_q <= timeout_d;
            mask_q    <= mask_d;
        end
    end

    assign core_rst           = core_rst_q;
    assign forwarding_enabled = fwd_q;
    assign running            = running_q;
    assign done               = done_q;
    assign timed_out          = timed_out_q;
    assign halted_mask        = mask_q;
    assign cycle_count        = run_cnt;

endmodule

// File: tb/tb_arm_run_controller.sv
// Self-checking bench for arm_run_controller: directed scenarios plus random
// start/abort/halt traffic against a behavioural model of the run sequence.
module tb_arm_run_controller;

    localparam int NC  = 2;
    localparam int RC  = 2;
    localparam int CW  = 16;
    localparam int DEF = 500;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [CW-1:0] timeout_cycles;
    logic [NC-1:0] fwd_mode_in;
    logic [NC-1:0] core_halted;
    logic [NC-1:0] core_rst;
    logic [NC-1:0] forwarding_enabled;
    logic          running;
    logic          done;
    logic          timed_out;
    logic [NC-1:0] halted_mask;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    arm_run_controller #(
        .NUM_CORES       (NC),
        .RESET_CYCLES    (RC),
        .CNT_W           (CW),
        .DEFAULT_TIMEOUT (DEF)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .timeout_cycles     (timeout_cycles),
        .fwd_mode_in        (fwd_mode_in),
        .core_halted        (core_halted),
        .core_rst           (core_rst),
        .forwarding_enabled (forwarding_enabled),
        .running            (running),
        .done               (done),
        .timed_out          (timed_out),
        .halted_mask        (halted_mask),
        .cycle_count        (cycle_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The model describes the run as: idle, some stretch cycles left, running, finished.
    bit       m_idle;
    int       m_stretch_left;
    bit       m_running;
    bit       m_done;
    bit       m_to;
    bit [1:0] m_fwd;
    bit [1:0] m_mask;
    int       m_cnt;
    int       m_limit;

    function automatic void model_reset();
        m_idle = 1; m_stretch_left = 0; m_running = 0; m_done = 0; m_to = 0;
        m_fwd = 0; m_mask = 0; m_cnt = 0; m_limit = DEF;
    endfunction

    // Effect of one clock edge given the inputs present before it.
    function automatic void model_step(bit s, bit a, int tc, bit [1:0] fwd, bit [1:0] halt);
        if (a) begin
            m_idle = 1; m_stretch_left = 0; m_running = 0; m_done = 0; m_to = 0; m_cnt = 0;
        end else if ((m_idle || m_done) && s) begin
            m_fwd = fwd;
            m_limit = (tc == 0) ? DEF : tc;
            m_mask = 0; m_cnt = 0;
            m_idle = 0; m_done = 0; m_to = 0;
            m_stretch_left = RC;
        end else if (m_stretch_left > 0) begin
            m_stretch_left--;
            if (m_stretch_left == 0) m_running = 1;
        end else if (m_running) begin
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            m_mask = m_mask | halt;
            if (m_mask == 2'b11) begin
                m_running = 0; m_done = 1; m_to = 0;
            end else if (m_cnt == m_limit) begin
                m_running = 0; m_done = 1; m_to = 1;
            end
        end
    endfunction

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #1;
        check("core_rst", 32'(core_rst), 32'((m_idle || m_stretch_left > 0) ? 2'b11 : 2'b00));
        check("running", 32'(running), 32'(m_running));
        check("done", 32'(done), 32'(m_done));
        check("timed_out", 32'(timed_out), 32'(m_to));
        check("fwd_en", 32'(forwarding_enabled), 32'(m_fwd));
        check("halted_mask", 32'(halted_mask), 32'(m_mask));
        check("cycle_count", 32'(cycle_count), 32'(m_cnt));
    end

    // ---------------- stimulus ----------------
    int halt_at [NC];
    bit rand_halts = 0;

    // One clock: drive inputs at the falling edge, advance model, wait for next falling edge.
    task automatic step(input bit s, input bit a);
        start = s;
        abort = a;
        if (!rand_halts) begin
            for (int i = 0; i < NC; i++) core_halted[i] = (m_cnt + 1 >= halt_at[i]);
        end
        model_step(s, a, int'(timeout_cycles), fwd_mode_in, core_halted);
        @(negedge clk);
        start = 0;
        abort = 0;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(0, 0);
            n++;
        end
        check("done_within_budget", 32'(done), 32'(1));
    endtask

    task automatic begin_run(input int tc, input bit [1:0] fwd, input int h0, input int h1);
        timeout_cycles = CW'(tc);
        fwd_mode_in    = fwd;
        halt_at[0]     = h0;
        halt_at[1]     = h1;
        step(1, 0);
    endtask

    initial begin
        rst = 0; start = 0; abort = 0;
        timeout_cycles = '0; fwd_mode_in = '0; core_halted = '0;
        halt_at[0] = 1000000; halt_at[1] = 1000000;
        model_reset();

        // Power-up
        repeat (3) @(negedge clk);
        check("pwr_core_rst", 32'(core_rst), 32'(2'b11));
        check("pwr_done", 32'(done), 32'(0));
        check("pwr_cycle_count", 32'(cycle_count), 32'(0));
        rst = 1;
        repeat (2) step(0, 0);

        // Halt completion: core 0 at RUN cycle 10, core 1 at cycle 40
        begin_run(100, 2'b10, 10, 40);
        check("stretch_edge1_core_rst", 32'(core_rst), 32'(2'b11));
        step(0, 0);
        check("stretch_edge2_core_rst", 32'(core_rst), 32'(2'b11));
        step(0, 0);
        check("run_core_rst", 32'(core_rst), 32'(2'b00));
        check("run_running", 32'(running), 32'(1));
        fwd_mode_in = 2'b01;
        timeout_cycles = CW'(3);
        for (int i = 0; i < 20 && m_cnt < 20; i++) step(0, 0);
        check("halt_mask_mid", 32'(halted_mask), 32'(2'b01));
        run_until_done(100);
        check("halt_cycle_count", 32'(cycle_count), 32'(40));
        check("halt_mask_final", 32'(halted_mask), 32'(2'b11));
        check("halt_timed_out", 32'(timed_out), 32'(0));
        check("halt_fwd", 32'(forwarding_enabled), 32'(2'b10));
        repeat (3) step(0, 0);
        check("done_sticky", 32'(done), 32'(1));

        // Timeout with default limit, restart from DONE
        begin_run(0, 2'b01, 5, 1000000);
        check("restart_core_rst", 32'(core_rst), 32'(2'b11));
        check("restart_mask_clr", 32'(halted_mask), 32'(2'b00));
        run_until_done(700);
        check("to_timed_out", 32'(timed_out), 32'(1));
        check("to_cycle_count", 32'(cycle_count), 32'(500));
        check("to_mask", 32'(halted_mask), 32'(2'b01));

        // Simultaneous halt and timeout: halt wins
        begin_run(20, 2'b00, 3, 20);
        run_until_done(40);
        check("sim_timed_out", 32'(timed_out), 32'(0));
        check("sim_cycle_count", 32'(cycle_count), 32'(20));

        // Abort at RUN cycle 7 together with start
        begin_run(100, 2'b11, 1000000, 1000000);
        for (int i = 0; i < 20 && !(m_running && m_cnt == 6); i++) step(0, 0);
        step(1, 1);
        check("abort_core_rst", 32'(core_rst), 32'(2'b11));
        check("abort_done", 32'(done), 32'(0));
        check("abort_cycle_count", 32'(cycle_count), 32'(0));
        check("abort_running", 32'(running), 32'(0));
        check("abort_fwd_kept", 32'(forwarding_enabled), 32'(2'b11));
        step(0, 0);
        check("abort_start_ignored", 32'(core_rst), 32'(2'b11));

        // Restart from DONE with new forwarding mode
        begin_run(30, 2'b00, 2, 4);
        run_until_done(40);
        check("pre_restart_count", 32'(cycle_count), 32'(4));
        begin_run(30, 2'b01, 1000000, 1000000);
        check("rs_core_rst_e1", 32'(core_rst), 32'(2'b11));
        check("rs_mask", 32'(halted_mask), 32'(2'b00));
        check("rs_fwd", 32'(forwarding_enabled), 32'(2'b01));
        fwd_mode_in = 2'b10;
        step(1, 0);
        check("rs_core_rst_e2", 32'(core_rst), 32'(2'b11));
        step(0, 0);
        check("rs_core_rst_run", 32'(core_rst), 32'(2'b00));
        check("rs_fwd_held", 32'(forwarding_enabled), 32'(2'b01));

        // Random traffic
        rand_halts = 1;
        for (int i = 0; i < 3000; i++) begin
            fwd_mode_in    = 2'($urandom);
            timeout_cycles = ($urandom_range(0, 7) == 0) ? CW'(0) : CW'($urandom_range(1, 40));
            for (int c = 0; c < NC; c++) core_halted[c] = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 15) == 0, $urandom_range(0, 59) == 0);
        end
        rand_halts = 0;

        // Asynchronous reset mid-run
        begin_run(200, 2'b11, 1000000, 1000000);
        repeat (5) step(0, 0);
        check("pre_rst_core_rst", 32'(core_rst), 32'(2'b00));
        #2;
        rst = 0;
        #1;
        check("async_rst_core_rst", 32'(core_rst), 32'(2'b11));
        check("async_rst_running", 32'(running), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) step(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
